// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
package project_types;

  typedef logic [31:0] pc_t;
  typedef logic        chip_status_t;
  typedef logic        reset_status_t;

  localparam reset_status_t RST_ENABLE  = 1'b0;
  localparam chip_status_t  CHIP_ENABLE = 1'b1;
  localparam logic [31:0]   NOP_INST    = 32'h0;

  // Number of un-acknowledged wait cycles tolerated before a bus timeout
  localparam logic [3:0]    WAIT_LIMIT  = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN
  } imem_state_t;

endpackage

// File: rtl/imem_responder_if.sv
// Instruction-memory bus: the responder is master, the memory is slave.
interface imem_responder_if;
  import project_types::*;

  logic        mem_req_o;
  pc_t         mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_ack_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_ack_i,
    output mem_rdata_i
  );

endinterface

// File: rtl/imem_responder.sv
// Fetch-side instruction responder with a one-entry buffer and flush draining.
// Optional bus timeout and sticky err_o are enabled by defining IMEM_TIMEOUT_EN.
module imem_responder
  import project_types::*;
(
  input  logic          clk,
  input  reset_status_t rst,
  input  pc_t           if_pc_i,
  input  chip_status_t  if_ce_i,
  input  logic          flush_i,
  output logic [31:0]   if_inst_o,
  output logic          stallreq_o,
`ifdef IMEM_TIMEOUT_EN
  output logic          err_o,
`endif
  imem_responder_if.master bus
);

  imem_state_t state;
  pc_t         addr_q;
  logic [31:0] data_q;
  logic        valid_q;
  logic        mem_req_q;
  pc_t         mem_addr_q;
  logic        hit;

`ifdef IMEM_TIMEOUT_EN
  logic [3:0]  wait_cnt;
  logic        err_q;

  assign err_o = err_q;
`endif

  assign hit            = valid_q && (addr_q == if_pc_i);
  assign stallreq_o     = (if_ce_i == CHIP_ENABLE) && !hit;
  assign if_inst_o      = hit ? data_q : NOP_INST;
  assign bus.mem_req_o  = mem_req_q;
  assign bus.mem_addr_o = mem_addr_q;

  // A started bus transaction always runs to its ack; a flush only decides
  // whether the returned word is kept (BUSY) or thrown away (DRAIN).
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state      <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
`ifdef IMEM_TIMEOUT_EN
      wait_cnt   <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (flush_i) begin
            valid_q <= 1'b0;
          end else if ((if_ce_i == CHIP_ENABLE) && !hit) begin
            mem_addr_q <= {if_pc_i[31:2], 2'b00};
            mem_req_q  <= 1'b1;
            state      <= BUSY;
`ifdef IMEM_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
          end
        end

        BUSY: begin
          if (bus.mem_ack_i) begin
            mem_req_q <= 1'b0;
            state     <= IDLE;
            if (flush_i) begin
              valid_q <= 1'b0;
            end else begin
              data_q  <= bus.mem_rdata_i;
              addr_q  <= mem_addr_q;
              valid_q <= 1'b1;
            end
          end else if (flush_i) begin
            valid_q <= 1'b0;
            state   <= DRAIN;
`ifdef IMEM_TIMEOUT_EN
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LIMIT - 4'd1) begin
            // Fetch resolves to a NOP so the pipeline is not stalled forever
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            data_q    <= NOP_INST;
            addr_q    <= mem_addr_q;
            valid_q   <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
`endif
          end
        end

        DRAIN: begin
          if (bus.mem_ack_i) begin
            mem_req_q <= 1'b0;
            state     <= IDLE;
`ifdef IMEM_TIMEOUT_EN
          end else if (wait_cnt == WAIT_LIMIT - 4'd1) begin
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios plus a randomized
// fetch sequence checked against a transaction-level buffer model.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] if_pc = 32'h0;
  logic        if_ce = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] if_inst;
  logic        stallreq;
`ifdef IMEM_TIMEOUT_EN
  logic        err;
`endif

  imem_responder_if bus();

  imem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .if_pc_i    (if_pc),
    .if_ce_i    (if_ce),
    .flush_i    (flush),
    .if_inst_o  (if_inst),
    .stallreq_o (stallreq),
`ifdef IMEM_TIMEOUT_EN
    .err_o      (err),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] salt         = 32'h0;
  int          lat          = 0;
  bit          mem_auto     = 1'b1;
  int          wcnt         = 0;
  int          stray_req    = 0;
  int          stray_done   = 0;
  bit          ref_valid    = 1'b0;
  logic [31:0] ref_addr     = 32'h0;
  logic [31:0] ref_data     = 32'h0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h3C01_0001;
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // Memory model: acks `lat` cycles after seeing a request, one-cycle strobe
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = 32'h0;
      wcnt            = 0;
    end else if (stray_req != stray_done) begin
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = 32'hDEAD_BEEF;
      stray_done      = stray_done + 1;
    end else if (bus.mem_ack_i) begin
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = $urandom;
    end else if (bus.mem_req_o && mem_auto) begin
      if (wcnt >= lat) begin
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = word_at(bus.mem_addr_o);
        wcnt            = 0;
      end else begin
        wcnt = wcnt + 1;
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0; if_ce = 1'b0; flush = 1'b0; if_pc = 32'h0; lat = 0; mem_auto = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ref_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; if_ce = 1'b1; if_pc = 32'h0; flush = 1'b0;
    #1;
    tests_run++;
    if ({bus.mem_req_o, bus.mem_addr_o} !== {1'b0, 32'h0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_bus: got %h expected %h", {bus.mem_req_o, bus.mem_addr_o}, {1'b0, 32'h0});
    end
    tests_run++;
    if ({stallreq, if_inst} !== {1'b1, 32'h0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_ce_on: got %h expected %h", {stallreq, if_inst}, {1'b1, 32'h0});
    end
    if_ce = 1'b0;
    #1;
    tests_run++;
    if ({stallreq, if_inst} !== {1'b0, 32'h0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_ce_off: got %h expected %h", {stallreq, if_inst}, {1'b0, 32'h0});
    end
`ifdef IMEM_TIMEOUT_EN
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_err: got %b expected 0", err);
    end
`endif
  endtask

  task automatic test_first_fetch();
    pulse_reset();
    @(negedge clk);
    if_ce = 1'b1; if_pc = 32'h0; lat = 0;
    #1;
    tests_run++;
    if ({stallreq, if_inst} !== {1'b1, 32'h0}) begin
      tests_failed++;
      $display("[TB] FAIL first_fetch_c0: got %h expected %h", {stallreq, if_inst}, {1'b1, 32'h0});
    end
    @(negedge clk); #1;
    tests_run++;
    if ({bus.mem_req_o, bus.mem_addr_o, stallreq} !== {1'b1, 32'h0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL first_fetch_c1: got %h expected %h", {bus.mem_req_o, bus.mem_addr_o, stallreq}, {1'b1, 32'h0, 1'b1});
    end
    @(negedge clk); #1;
    tests_run++;
    if ({stallreq, if_inst} !== {1'b0, 32'h3C01_0001}) begin
      tests_failed++;
      $display("[TB] FAIL first_fetch_c2: got %h expected %h", {stallreq, if_inst}, {1'b0, 32'h3C01_0001});
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    if_pc = 32'h4; lat = 1;
    for (int c = 0; c < 3; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      tests_run++;
      if ({stallreq, if_inst} !== {1'b1, 32'h0}) begin
        tests_failed++;
        $display("[TB] FAIL hold_miss_c%0d: got %h expected %h", c, {stallreq, if_inst}, {1'b1, 32'h0});
      end
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      tests_run++;
      if ({bus.mem_req_o, stallreq, if_inst} !== {1'b0, 1'b0, word_at(32'h4)}) begin
        tests_failed++;
        $display("[TB] FAIL hold_stable_%0d: got %h expected %h", c, {bus.mem_req_o, stallreq, if_inst}, {1'b0, 1'b0, word_at(32'h4)});
      end
    end
  endtask

  task automatic test_flush_busy();
    @(negedge clk);
    if_pc = 32'h8; lat = 2;
    @(negedge clk); #1;
    tests_run++;
    if ({bus.mem_req_o, bus.mem_addr_o} !== {1'b1, 32'h8}) begin
      tests_failed++;
      $display("[TB] FAIL flush_busy_req: got %h expected %h", {bus.mem_req_o, bus.mem_addr_o}, {1'b1, 32'h8});
    end
    flush = 1'b1; if_pc = 32'h100;
    @(negedge clk);
    flush = 1'b0;
    for (int c = 0; c < 2; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      tests_run++;
      if ({bus.mem_req_o, stallreq, if_inst} !== {1'b1, 1'b1, 32'h0}) begin
        tests_failed++;
        $display("[TB] FAIL flush_drain_%0d: got %h expected %h", c, {bus.mem_req_o, stallreq, if_inst}, {1'b1, 1'b1, 32'h0});
      end
    end
    @(negedge clk); #1;
    tests_run++;
    if ({bus.mem_req_o, if_inst} !== {1'b0, 32'h0}) begin
      tests_failed++;
      $display("[TB] FAIL flush_discard: got %h expected %h", {bus.mem_req_o, if_inst}, {1'b0, 32'h0});
    end
    @(negedge clk); #1;
    tests_run++;
    if ({bus.mem_req_o, bus.mem_addr_o} !== {1'b1, 32'h100}) begin
      tests_failed++;
      $display("[TB] FAIL flush_new_pc: got %h expected %h", {bus.mem_req_o, bus.mem_addr_o}, {1'b1, 32'h100});
    end
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if ({stallreq, if_inst} !== {1'b0, word_at(32'h100)}) begin
      tests_failed++;
      $display("[TB] FAIL flush_refetch: got %h expected %h", {stallreq, if_inst}, {1'b0, word_at(32'h100)});
    end
  endtask

  task automatic test_flush_ack();
    @(negedge clk);
    if_pc = 32'hC; lat = 0;
    @(negedge clk);
    flush = 1'b1;
    #1;
    tests_run++;
    if ({bus.mem_req_o, bus.mem_addr_o} !== {1'b1, 32'hC}) begin
      tests_failed++;
      $display("[TB] FAIL flush_ack_req: got %h expected %h", {bus.mem_req_o, bus.mem_addr_o}, {1'b1, 32'hC});
    end
    @(negedge clk);
    flush = 1'b0; if_ce = 1'b0;
    #1;
    tests_run++;
    if ({bus.mem_req_o, stallreq, if_inst} !== {1'b0, 1'b0, 32'h0}) begin
      tests_failed++;
      $display("[TB] FAIL flush_ack_drop: got %h expected %h", {bus.mem_req_o, stallreq, if_inst}, {1'b0, 1'b0, 32'h0});
    end
    if_ce = 1'b1;
    #1;
    tests_run++;
    if (stallreq !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL flush_ack_invalid: got %b expected 1", stallreq);
    end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    @(negedge clk);
    if_ce = 1'b1; if_pc = 32'h20; lat = 10;
    @(negedge clk); #1;
    tests_run++;
    if (bus.mem_req_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_busy: got %b expected 1", bus.mem_req_o);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if ({bus.mem_req_o, bus.mem_addr_o} !== {1'b0, 32'h0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_abort: got %h expected %h", {bus.mem_req_o, bus.mem_addr_o}, {1'b0, 32'h0});
    end
    @(negedge clk);
    rst = 1'b1; if_ce = 1'b0; stray_req = stray_req + 1;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if ({bus.mem_req_o, if_inst} !== {1'b0, 32'h0}) begin
      tests_failed++;
      $display("[TB] FAIL stray_ack_ignored: got %h expected %h", {bus.mem_req_o, if_inst}, {1'b0, 32'h0});
    end
    if_ce = 1'b1;
    #1;
    tests_run++;
    if (stallreq !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL stray_ack_nocapture: got %b expected 1", stallreq);
    end
  endtask

  task automatic test_random();
    logic [31:0] pool [6];
    logic [31:0] pc;
    bit          ce;
    bit          exp_hit;
    int          k;
    pool[0] = 32'h0;
    pool[1] = 32'h4;
    pool[2] = 32'h1000;
    pool[3] = 32'hFFFF_FFFC;
    pool[4] = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    pool[5] = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    pulse_reset();
    for (int s = 0; s < 60; s++) begin
      pc = pool[$urandom_range(0, 5)];
      ce = ($urandom_range(0, 3) != 0);
      k  = $urandom_range(0, 3);
      @(negedge clk);
      if_pc = pc; if_ce = ce; lat = k;
      exp_hit = ref_valid && (ref_addr == pc);
      #1;
      if (ce && !exp_hit) begin
        tests_run++;
        if ({stallreq, if_inst} !== {1'b1, 32'h0}) begin
          tests_failed++;
          $display("[TB] FAIL rnd_miss_start s%0d: got %h expected %h", s, {stallreq, if_inst}, {1'b1, 32'h0});
        end
        for (int c = 0; c <= k; c++) begin
          @(negedge clk); #1;
          tests_run++;
          if ({bus.mem_req_o, bus.mem_addr_o, stallreq} !== {1'b1, pc, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL rnd_busy s%0d c%0d: got %h expected %h", s, c, {bus.mem_req_o, bus.mem_addr_o, stallreq}, {1'b1, pc, 1'b1});
          end
        end
        @(negedge clk); #1;
        tests_run++;
        if ({bus.mem_req_o, stallreq, if_inst} !== {1'b0, 1'b0, word_at(pc)}) begin
          tests_failed++;
          $display("[TB] FAIL rnd_done s%0d: got %h expected %h", s, {bus.mem_req_o, stallreq, if_inst}, {1'b0, 1'b0, word_at(pc)});
        end
        ref_valid = 1'b1; ref_addr = pc; ref_data = word_at(pc);
      end else begin
        tests_run++;
        if ({stallreq, if_inst} !== {1'b0, (exp_hit ? ref_data : 32'h0)}) begin
          tests_failed++;
          $display("[TB] FAIL rnd_idle s%0d: got %h expected %h", s, {stallreq, if_inst}, {1'b0, (exp_hit ? ref_data : 32'h0)});
        end
        @(negedge clk); #1;
        tests_run++;
        if (bus.mem_req_o !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL rnd_noreq s%0d: got %b expected 0", s, bus.mem_req_o);
        end
      end
    end
  endtask

`ifdef IMEM_TIMEOUT_EN
  task automatic test_timeout();
    int high;
    high = 0;
    pulse_reset();
    @(negedge clk);
    mem_auto = 1'b0; if_ce = 1'b1; if_pc = 32'h40;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (bus.mem_req_o !== 1'b1) break;
      high++;
    end
    tests_run++;
    if (high != 15) begin
      tests_failed++;
      $display("[TB] FAIL timeout_cycles: got %0d expected 15", high);
    end
    tests_run++;
    if ({err, stallreq, if_inst} !== {1'b1, 1'b0, 32'h0}) begin
      tests_failed++;
      $display("[TB] FAIL timeout_state: got %h expected %h", {err, stallreq, if_inst}, {1'b1, 1'b0, 32'h0});
    end
  endtask
`endif

  initial begin
    salt = $urandom;
    test_reset();
    test_first_fetch();
    test_hold();
    test_flush_busy();
    test_flush_ack();
    test_reset_mid();
    test_random();
`ifdef IMEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  reset_status_t; asynchronous, active-low (RST_ENABLE = 1'b0).
REQ-003 SHALL have port if_pc_i  in  32  pc_t fetch address from the fetch stage.
REQ-004 SHALL have port if_ce_i  in  1  chip_status_t fetch enable from the fetch stage.
REQ-005 SHALL have port flush_i  in  1  discard any outstanding fetch (taken jump or exception).
REQ-006 SHALL have port if_inst_o  out  32  instruction for if_pc_i; 32'h0 (NOP) when not valid.
REQ-007 SHALL have port stallreq_o  out  1  requests a pipeline stall until the current fetch completes.
REQ-008 SHALL have port mem_req_o  out  1  bus request to the instruction memory.
REQ-009 SHALL have port mem_addr_o  out  32  word address; bits [1:0] forced to 0.
REQ-010 SHALL have port mem_ack_i  in  1  single-cycle completion strobe from memory.
REQ-011 SHALL have port mem_rdata_i  in  32  read data; valid only while mem_ack_i = 1.
REQ-012 SHALL have port err_o  out  1  sticky bus-timeout flag; exists only under IMEM_TIMEOUT_EN.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DRAIN.
REQ-014 SHALL hold a one-entry buffer of addr_q (32), data_q (32), and valid_q.
REQ-015 SHALL define hit = valid_q AND (addr_q == if_pc_i), combinationally.
REQ-016 SHALL drive stallreq_o = (if_ce_i == CHIP_ENABLE) AND NOT hit, combinationally, in every state.
REQ-017 SHALL drive if_inst_o = hit ? data_q : 32'h0, combinationally.
REQ-018 IDLE, with if_ce_i enabled, NOT hit, and flush_i = 0: SHALL register mem_addr_o <= if_pc_i and mem_req_o <= 1, then go to BUSY.
REQ-019 BUSY: SHALL hold mem_req_o and mem_addr_o stable until mem_ack_i is sampled high.
REQ-020 BUSY on ack: SHALL capture data_q <= mem_rdata_i, addr_q <= mem_addr_o, and valid_q <= 1, drop mem_req_o, and go to IDLE.
REQ-021 Minimum latency, with ack in the first BUSY cycle: SHALL make the PC presented in cycle N produce a hit in cycle N+2, with stallreq_o high in cycles N and N+1.
REQ-022 flush_i in BUSY without ack: SHALL clear valid_q and go to DRAIN, keeping mem_req_o high (a bus transaction is never abandoned).
REQ-023 flush_i in BUSY in the same cycle as ack: SHALL discard the data, clear valid_q, and go to IDLE.
REQ-024 DRAIN: SHALL discard data on ack, drop mem_req_o, and go to IDLE.
REQ-025 flush_i in IDLE: SHALL clear valid_q and issue no request that cycle.
REQ-026 SHALL ignore mem_ack_i while mem_req_o = 0.
REQ-027 if_ce_i disabled: SHALL issue no new request, while any in-flight transaction still completes normally.
REQ-028 Address wrap from 32'hFFFF_FFFC to 0: SHALL need no special handling; it is a plain miss.

Reset
REQ-029 rst low: SHALL immediately put the FSM in IDLE and set mem_req_o = 0, mem_addr_o = 0, addr_q = 0, data_q = 0, valid_q = 0, and err_o = 0.
REQ-030 Reset mid-transaction: SHALL abort locally; a late mem_ack_i after release is ignored per REQ-026.

Configuration
REQ-031 IMEM_TIMEOUT_EN defined: SHALL add a 4-bit wait counter, cleared when entering BUSY or DRAIN.
REQ-032 IMEM_TIMEOUT_EN defined: when the counter reaches 15 without ack, SHALL drop mem_req_o, set err_o, load data_q = 0 with valid_q = 1 (BUSY only), and go to IDLE.
REQ-033 IMEM_TIMEOUT_EN undefined: SHALL omit both the counter and err_o, and SHALL wait for ack indefinitely.

Structure
REQ-034 SHALL place pc_t, chip_status_t, reset_status_t, RST_ENABLE, CHIP_ENABLE, NOP_INST (32'h0), and the imem_state_t enum in project_types.
REQ-035 SHALL be a single module with no sub-modules; the optional timeout counter is inline.

Verification
REQ-036 Reset release, ce on, pc = 0, memory acks after 1 cycle with 32'h3C01_0001 -> stallreq_o high for 2 cycles, then if_inst_o = 32'h3C01_0001 with stallreq_o = 0.
REQ-037 pc held at 0x4 after a completed fetch -> no new mem_req_o, and if_inst_o stays stable.
REQ-038 flush_i in BUSY at pc 0x8, ack 3 cycles later -> enters DRAIN, data discarded, next request uses the new pc 0x100.
REQ-039 flush_i in the same cycle as ack -> valid_q = 0 and if_inst_o = 0.
REQ-040 rst asserted mid-BUSY -> mem_req_o = 0 immediately; a stray ack after release causes no capture.
REQ-041 Under IMEM_TIMEOUT_EN with no ack -> mem_req_o drops after 15 BUSY cycles, err_o = 1, and if_inst_o = 0 with stallreq_o = 0.
